axis_crc32_insert: RTL and testbench
====================================

AXIS_CRC32_INSERT -- requirements
Module: axis_crc32_insert

Interface
REQ-001 Parameter CRC_INIT, default 32'hFFFFFFFF: CRC register value at the start of every frame.
REQ-002 Parameter CRC_XOROUT, default 32'hFFFFFFFF: value XORed with the CRC register to form the FCS.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, exactly as follows:
clk  input  1  sole clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
REQ-004 Ports (direction, width, meaning):
s_axis_tdata  input  8  payload byte
s_axis_tvalid  input  1  input byte valid
s_axis_tready  output  1  block accepts the input byte
s_axis_tlast  input  1  last payload byte of the frame
s_axis_tuser  input  1  frame error flag; sampled on the tlast byte
m_axis_tdata  output  8  payload byte or FCS byte
m_axis_tvalid  output  1  output byte valid
m_axis_tready  input  1  downstream accepts the output byte
m_axis_tlast  output  1  last byte of the frame (final FCS byte)
m_axis_tuser  output  1  frame error flag

Function
REQ-005 The CRC SHALL use an instance of the codebase lfsr module, configured as LFSR_WIDTH=32, LFSR_POLY=32'h04C11DB7, GALOIS, REVERSE=1, DATA_WIDTH=8, OUTPUT_WIDTH=32, STYLE "AUTO".
REQ-006 Each accepted payload byte SHALL update the CRC register: crc <= lfsr(data_in=byte, lfsr_in=crc).
REQ-007 The FCS SHALL equal the post-update CRC XOR CRC_XOROUT; it is emitted as 4 bytes, LSB first (fcs[7:0], [15:8], [23:16], [31:24]).
REQ-008 The state machine SHALL have two states:
- PAYLOAD: bytes pass through.
- FCS: 4 FCS bytes are emitted, tracked by a 2-bit counter 0..3.
REQ-009 Transfers SHALL occur only when tvalid and tready are both high.
REQ-010 The output stage SHALL be a single register: a byte accepted in cycle N appears on m_axis in cycle N+1.
REQ-011 In PAYLOAD: s_axis_tready = m_axis_tready OR NOT m_axis_tvalid. In FCS: s_axis_tready = 0.
REQ-012 Payload bytes SHALL be forwarded with m_axis_tlast=0 and m_axis_tuser=0, including the input tlast byte.
REQ-013 Accepting a byte with s_axis_tlast=1 SHALL:
- latch the FCS and s_axis_tuser;
- move to FCS with the counter at 0;
- reset the CRC register to CRC_INIT.
REQ-014 In FCS, each output transfer SHALL load the next FCS byte.
REQ-015 The 4th FCS byte SHALL carry m_axis_tlast=1 and m_axis_tuser equal to the latched tuser; it returns the block to PAYLOAD.
REQ-016 The output register SHALL hold its data and flags stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-017 With no backpressure, a frame of N bytes SHALL emit N+4 bytes on N+4 consecutive cycles; s_axis_tready SHALL be low for exactly 4 cycles after the tlast byte.
REQ-018 The first byte of the next frame MAY be accepted in the cycle the final FCS byte is handed off; it SHALL use CRC_INIT.
REQ-019 The block SHALL handle a 1-byte frame (tlast on the first byte) normally; it imposes no maximum frame length.

Reset
REQ-020 Reset SHALL apply in any state, including mid-frame and mid-FCS, and SHALL set:
- state = PAYLOAD, counter = 0, crc = CRC_INIT;
- m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tuser = 0, m_axis_tdata = 0;
- s_axis_tready = 0 while rst is high.
REQ-021 A partial frame in progress at reset SHALL be discarded without an FCS; the first byte accepted after reset starts a new frame.

Verification
REQ-022 ASCII "123456789" with tlast on "9", m_axis_tready=1 -> 13 output bytes; the last four are 26 39 F4 CB; tlast only on CB.
REQ-023 Single byte 0x00 with tlast -> output 00 8D EF 02 D2; tlast on D2.
REQ-024 "123456789" sent twice back-to-back -> both frames end 26 39 F4 CB, confirming CRC reinitialisation.
REQ-025 m_axis_tready pseudo-random 50% on REQ-022 stimulus -> identical byte sequence, no drops or duplicates; s_axis_tready=0 throughout FCS.
REQ-026 rst pulsed after 5 bytes of a frame, then "123456789" sent -> outputs cleared on reset; the new frame ends 26 39 F4 CB.
REQ-027 Frame with s_axis_tuser=1 on its tlast byte -> m_axis_tuser=1 only on the final FCS byte; FCS bytes unaffected.

Source files
------------

// File: rtl/axis_crc32_insert_if.sv
// rtl/axis_crc32_insert_if.sv - byte-wide AXI-Stream bundle carrying a frame error flag
interface axis_crc32_insert_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, input tready, output tlast, output tuser);
  modport slave  (input tdata, input tvalid, output tready, input tlast, input tuser);
endinterface

// File: rtl/axis_crc32_insert.sv
// rtl/axis_crc32_insert.sv - appends a 4-byte CRC-32 FCS to each AXI-Stream byte frame

// Combinational LFSR / CRC step: advances the register by DATA_WIDTH input bits.
module lfsr #(
  parameter int                    LFSR_WIDTH   = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 32'h04C11DB7,
  parameter string                 LFSR_CONFIG  = "GALOIS",
  parameter bit                    REVERSE      = 1'b1,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    OUTPUT_WIDTH = 32,
  parameter string                 STYLE        = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [LFSR_WIDTH-1:0]   lfsr_in,
  output logic [OUTPUT_WIDTH-1:0] lfsr_out
);

  function automatic logic [LFSR_WIDTH-1:0] bit_reverse(input logic [LFSR_WIDTH-1:0] v);
    for (int i = 0; i < LFSR_WIDTH; i++) bit_reverse[i] = v[LFSR_WIDTH-1-i];
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_REV  = bit_reverse(LFSR_POLY);
  localparam bit                    IS_GALOIS = (LFSR_CONFIG == "GALOIS");

  // One bit time of the register; reflected mode shifts toward bit 0.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s, input logic d);
    logic fb;
    if (IS_GALOIS) begin
      if (REVERSE) begin
        fb = s[0] ^ d;
        lfsr_step = (s >> 1) ^ (fb ? POLY_REV : '0);
      end else begin
        fb = s[LFSR_WIDTH-1] ^ d;
        lfsr_step = (s << 1) ^ (fb ? LFSR_POLY : '0);
      end
    end else begin
      if (REVERSE) begin
        fb = (^(s & POLY_REV)) ^ d;
        lfsr_step = {fb, s[LFSR_WIDTH-1:1]};
      end else begin
        fb = (^(s & LFSR_POLY)) ^ d;
        lfsr_step = {s[LFSR_WIDTH-2:0], fb};
      end
    end
  endfunction

  // Input bits in the order they are shifted in: LSB first when reflected.
  logic [DATA_WIDTH-1:0] data_ord;
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_ord
    assign data_ord[i] = REVERSE ? data_in[i] : data_in[DATA_WIDTH-1-i];
  end

  logic [LFSR_WIDTH-1:0] state_final;

  if (STYLE == "UNROLLED") begin : g_unrolled
    logic [LFSR_WIDTH-1:0] chain [DATA_WIDTH+1];
    assign chain[0] = lfsr_in;
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      assign chain[i+1] = lfsr_step(chain[i], data_ord[i]);
    end
    assign state_final = chain[DATA_WIDTH];
  end else begin : g_loop
    // Serial bit loop, flattened into parallel XOR logic by synthesis.
    always_comb begin
      state_final = lfsr_in;
      for (int i = 0; i < DATA_WIDTH; i++) state_final = lfsr_step(state_final, data_ord[i]);
    end
  end

  assign lfsr_out = state_final[OUTPUT_WIDTH-1:0];

endmodule

module axis_crc32_insert #(
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_crc32_insert_if.slave         s_axis,
  axis_crc32_insert_if.master        m_axis
);

  typedef enum logic {ST_PAYLOAD, ST_FCS} state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] crc_q;
  logic [31:0] fcs_q;
  logic        tuser_q;
  logic [7:0]  m_tdata_q;
  logic        m_tvalid_q;
  logic        m_tlast_q;
  logic        m_tuser_q;

  logic [31:0] crc_upd;
  logic [7:0]  fcs_byte;
  logic        out_ready;
  logic        s_tready;
  logic        s_fire;

  lfsr #(
    .LFSR_WIDTH  (32),
    .LFSR_POLY   (32'h04C11DB7),
    .LFSR_CONFIG ("GALOIS"),
    .REVERSE     (1'b1),
    .DATA_WIDTH  (8),
    .OUTPUT_WIDTH(32),
    .STYLE       ("AUTO")
  ) u_crc (
    .data_in (s_axis.tdata),
    .lfsr_in (crc_q),
    .lfsr_out(crc_upd)
  );

  // The single output register may be (re)loaded when empty or being drained.
  assign out_ready = m_axis.tready | ~m_tvalid_q;
  assign s_tready  = ~rst & (state_q == ST_PAYLOAD) & out_ready;
  assign s_fire    = s_tready & s_axis.tvalid;

  assign s_axis.tready = s_tready;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tlast  = m_tlast_q;
  assign m_axis.tuser  = m_tuser_q;

  // Select the FCS byte for the current position, least significant first.
  always_comb begin
    fcs_byte = fcs_q[7:0];
    case (cnt_q)
      2'd0: fcs_byte = fcs_q[7:0];
      2'd1: fcs_byte = fcs_q[15:8];
      2'd2: fcs_byte = fcs_q[23:16];
      2'd3: fcs_byte = fcs_q[31:24];
    endcase
  end

  // Frame FSM, running CRC and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PAYLOAD;
      cnt_q      <= 2'd0;
      crc_q      <= CRC_INIT;
      fcs_q      <= 32'd0;
      tuser_q    <= 1'b0;
      m_tdata_q  <= 8'd0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_PAYLOAD: begin
          if (s_fire) begin
            m_tdata_q  <= s_axis.tdata;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
            if (s_axis.tlast) begin
              fcs_q   <= crc_upd ^ CRC_XOROUT;
              tuser_q <= s_axis.tuser;
              crc_q   <= CRC_INIT;
              cnt_q   <= 2'd0;
              state_q <= ST_FCS;
            end else begin
              crc_q <= crc_upd;
            end
          end else if (m_axis.tready) begin
            m_tvalid_q <= 1'b0;
          end
        end
        ST_FCS: begin
          if (out_ready) begin
            m_tdata_q  <= fcs_byte;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= (cnt_q == 2'd3);
            m_tuser_q  <= (cnt_q == 2'd3) & tuser_q;
            cnt_q      <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= ST_PAYLOAD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_crc32_insert.sv
// tb/tb_axis_crc32_insert.sv - randomized self-checking bench for axis_crc32_insert
module tb_axis_crc32_insert;

  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  axis_crc32_insert_if s_if();
  axis_crc32_insert_if m_if();

  axis_crc32_insert #(.CRC_INIT(CRC_INIT), .CRC_XOROUT(CRC_XOROUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axis(s_if),
    .m_axis(m_if)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] crc_tab [256];
  logic [9:0]  exp_q[$];     // {tuser, tlast, tdata} still owed by the DUT
  logic [9:0]  out_log[$];   // every byte handed off downstream
  logic [31:0] model_crc = CRC_INIT;
  bit          rdy_rand = 1'b0;
  bit          rst_seen = 1'b0;
  bit          stall_q = 1'b0;
  logic [9:0]  stall_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    return crc_tab[c[7:0] ^ b] ^ (c >> 8);
  endfunction

  function automatic logic [31:0] crc_of(input logic [7:0] bytes[$]);
    logic [31:0] c;
    c = CRC_INIT;
    foreach (bytes[i]) c = crc_byte(c, bytes[i]);
    return c ^ CRC_XOROUT;
  endfunction

  // downstream ready: always on, or a fresh coin toss each cycle
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // transaction-level model: what is owed downstream, and when input may be taken
  always @(negedge clk) begin
    logic [9:0]  cur;
    logic [31:0] fcs;
    cur = {m_if.tuser, m_if.tlast, m_if.tdata};
    if (rst) begin
      chk("rst_s_tready", 32'(s_if.tready), 32'd0);
      if (rst_seen) chk("rst_outputs", {21'd0, m_if.tvalid, cur}, 32'd0);
      exp_q.delete();
      model_crc = CRC_INIT;
      rst_seen  = 1'b1;
      stall_q   = 1'b0;
    end else begin
      if (rst_seen) begin
        chk("post_rst_outputs", {21'd0, m_if.tvalid, cur}, 32'd0);
        rst_seen = 1'b0;
      end
      chk("m_tvalid", 32'(m_if.tvalid), 32'(exp_q.size() > 0));
      chk("s_tready", 32'(s_if.tready),
          exp_q.size() == 0 ? 32'd1 : exp_q.size() == 1 ? 32'(m_if.tready) : 32'd0);
      if (stall_q) chk("hold_stable", {22'd0, cur}, {22'd0, stall_val});
      if (m_if.tvalid && m_if.tready && exp_q.size() > 0) begin
        chk("out_byte", {22'd0, cur}, {22'd0, exp_q[0]});
        void'(exp_q.pop_front());
        out_log.push_back(cur);
      end
      stall_q   = m_if.tvalid && !m_if.tready;
      stall_val = cur;
      if (s_if.tvalid && s_if.tready) begin
        model_crc = crc_byte(model_crc, s_if.tdata);
        exp_q.push_back({2'b00, s_if.tdata});
        if (s_if.tlast) begin
          fcs = model_crc ^ CRC_XOROUT;
          exp_q.push_back({2'b00, fcs[7:0]});
          exp_q.push_back({2'b00, fcs[15:8]});
          exp_q.push_back({2'b00, fcs[23:16]});
          exp_q.push_back({s_if.tuser, 1'b1, fcs[31:24]});
          model_crc = CRC_INIT;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    int guard;
    guard = 0;
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    s_if.tlast  = last;
    s_if.tuser  = user;
    forever begin
      @(negedge clk);
      if (s_if.tready) break;
      guard++;
      if (guard > 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: s_tready stayed 0, expected 1 within 1000 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input logic user, input bit gaps);
    foreach (bytes[i]) begin
      send_byte(bytes[i], i == bytes.size() - 1, user);
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin @(negedge clk); g++; end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_log(input logic [9:0] expv[$]);
    chk("log_len", 32'(out_log.size()), 32'(expv.size()));
    foreach (expv[i]) begin
      if (i < out_log.size()) chk($sformatf("log[%0d]", i), {22'd0, out_log[i]}, {22'd0, expv[i]});
    end
  endtask

  initial begin
    logic [7:0]  s9[$];
    logic [7:0]  one0[$];
    logic [7:0]  fr[$];
    logic [9:0]  exp9[$];
    logic [9:0]  expv[$];
    logic [31:0] v;
    int          len;

    for (int i = 0; i < 256; i++) begin
      v = 32'(i);
      for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      crc_tab[i] = v;
    end

    s9   = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    one0 = {8'h00};
    chk("model_crc_123456789", crc_of(s9), 32'hCBF43926);
    chk("model_crc_00", crc_of(one0), 32'hD202EF8D);

    foreach (s9[i]) exp9.push_back({2'b00, s9[i]});
    exp9.push_back(10'h026);
    exp9.push_back(10'h039);
    exp9.push_back(10'h0F4);
    exp9.push_back(10'h1CB);

    s_if.tdata  = 8'd0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // "123456789", no backpressure
    out_log.delete();
    send_frame(s9, 1'b0, 1'b0);
    wait_drain();
    check_log(exp9);

    // single zero byte
    out_log.delete();
    send_frame(one0, 1'b0, 1'b0);
    wait_drain();
    expv = {10'h000, 10'h08D, 10'h0EF, 10'h002, 10'h1D2};
    check_log(expv);

    // two frames back to back
    out_log.delete();
    send_frame(s9, 1'b0, 1'b0);
    send_frame(s9, 1'b0, 1'b0);
    wait_drain();
    expv = {exp9, exp9};
    check_log(expv);

    // random downstream backpressure
    rdy_rand = 1'b1;
    out_log.delete();
    send_frame(s9, 1'b0, 1'b0);
    wait_drain();
    check_log(exp9);
    rdy_rand = 1'b0;

    // reset in the middle of a frame, then a clean frame
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_log.delete();
    send_frame(s9, 1'b0, 1'b0);
    wait_drain();
    check_log(exp9);

    // error flag on the tlast byte
    out_log.delete();
    send_frame(s9, 1'b1, 1'b0);
    wait_drain();
    expv = exp9;
    expv[12] = 10'h3CB;
    check_log(expv);

    // random frames, random gaps, random backpressure
    rdy_rand = 1'b1;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 24);
      fr.delete();
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
      send_frame(fr, 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_drain();
    rdy_rand = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
